uart_tx_fsm: RTL and testbench

- UART transmitter, companion to the team's UART receiver; drives the serial line the receiver samples.
- Accepts one DATA_BITS word per valid/ready handshake from the TX FIFO.
- Frame format, MSB first: start bit (0), DATA_BITS data bits, one parity bit, STOP_BITS stop bits (1).
- Gated by the far end's RTS, which arrives on CTS. Fully synchronous to Clk: no derived clocks.

---
 rtl/uart_tx_fsm_if.sv | 11 +
 rtl/uart_tx_fsm.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fsm.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fsm_if.sv
// Word handshake between the TX FIFO (master) and the UART transmitter (slave).
interface uart_tx_fsm_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Tx_Data_In;
    logic                 Tx_Valid;
    logic                 Tx_Ready;

    modport master (output Tx_Data_In, output Tx_Valid, input Tx_Ready);
    modport slave  (input Tx_Data_In, input Tx_Valid, output Tx_Ready);
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, DATA_BITS data bits MSB first, parity, STOP_BITS stop bits.
// Words are accepted only while the far end's RTS (our CTS) is high; all outputs registered.
module uart_tx_fsm #(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 2,
    parameter int SYSCLOCK_FREQ = 100000,
    parameter int BAUDRATE      = 9600,
    parameter int PARITY_ODD    = 0
) (
    input  logic          Clk,
    input  logic          Rst,
    uart_tx_fsm_if.slave  tx_if,
    input  logic          CTS,
    output logic          Tx_Out,
    output logic          Tx_Busy,
    output logic          Tx_Done
);
    localparam int BAUD_PULSE_COUNT = SYSCLOCK_FREQ / (16 * BAUDRATE);
    localparam int BIT_CLKS         = 16 * (BAUD_PULSE_COUNT + 1);
    localparam int STOP_CLKS        = STOP_BITS * BIT_CLKS;
    localparam int MAX_HOLD         = (STOP_CLKS > BIT_CLKS) ? STOP_CLKS : BIT_CLKS;
    localparam int TIMER_W          = $clog2(MAX_HOLD);
    localparam int IDX_W            = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int MSB              = DATA_BITS - 1;

    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(BIT_CLKS - 1);
    localparam logic [TIMER_W-1:0] STOP_LAST = TIMER_W'(STOP_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   tx_out_q, tx_out_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_done_q, tx_done_d;
    logic                   bit_end, stop_end;

    assign bit_end  = (timer_q == BIT_LAST);
    assign stop_end = (timer_q == STOP_LAST);

    // Outputs are computed for the state being entered, so each register
    // already shows the new bit value on the cycle the state changes.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d   = state_q;
        timer_d   = timer_q + TIMER_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_out_d  = tx_out_q;
        tx_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (tx_ready_q && tx_if.Tx_Valid && CTS) begin
                    state_d  = START;
                    shift_d  = tx_if.Tx_Data_In;
                    parity_d = (^tx_if.Tx_Data_In) ^ 1'(PARITY_ODD);
                    tx_out_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    timer_d   = '0;
                    bit_idx_d = IDX_W'(DATA_BITS - 1);
                    tx_out_d  = shift_q[MSB];
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == '0) begin
                        state_d  = PARITY;
                        tx_out_d = parity_q;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        shift_d   = {shift_q[MSB-1:0], 1'b0};
                        tx_out_d  = shift_d[MSB];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    timer_d  = '0;
                    tx_out_d = 1'b1;
                end
            end
            STOP: begin
                if (stop_end) begin
                    state_d   = DONE;
                    timer_d   = '0;
                    tx_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: begin
                state_d  = IDLE;
                timer_d  = '0;
                tx_out_d = 1'b1;
            end
        endcase

        tx_ready_d = (state_d == IDLE);
        tx_busy_d  = (state_d == START) || (state_d == DATA) ||
                     (state_d == PARITY) || (state_d == STOP);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the same pre-edge values.
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_if.Tx_Ready = tx_ready_q;
    assign Tx_Out         = tx_out_q;
    assign Tx_Busy        = tx_busy_q;
    assign Tx_Done        = tx_done_q;
endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: accepted words go to a scoreboard; a line monitor decodes
// Tx_Out like the receiver would and compares against a frame model.
module tb_uart_tx_fsm;
    localparam int SYSCLOCK_FREQ = 100000;
    localparam int BAUDRATE      = 9600;
    localparam int DATA_BITS     = 8;
    localparam int STOP_BITS     = 2;
    localparam int BIT_CLKS      = 16 * (SYSCLOCK_FREQ / (16 * BAUDRATE) + 1);
    localparam int NUM_TX_BITS   = 1 + DATA_BITS + 1 + STOP_BITS;
    localparam int FRAME_CLKS    = NUM_TX_BITS * BIT_CLKS;

    typedef struct {
        logic [7:0] data;
        int         acc_cyc;
    } exp_t;

    logic Clk, Rst;
    logic cts, tx_out, tx_busy, tx_done;
    logic cts_o, tx_out_o, busy_o, done_o;

    uart_tx_fsm_if #(.DATA_BITS(DATA_BITS)) bus ();
    uart_tx_fsm_if #(.DATA_BITS(DATA_BITS)) bus_o ();

    uart_tx_fsm #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .SYSCLOCK_FREQ(SYSCLOCK_FREQ),
                  .BAUDRATE(BAUDRATE), .PARITY_ODD(0)) dut (
        .Clk(Clk), .Rst(Rst), .tx_if(bus), .CTS(cts),
        .Tx_Out(tx_out), .Tx_Busy(tx_busy), .Tx_Done(tx_done)
    );

    uart_tx_fsm #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .SYSCLOCK_FREQ(SYSCLOCK_FREQ),
                  .BAUDRATE(BAUDRATE), .PARITY_ODD(1)) dut_odd (
        .Clk(Clk), .Rst(Rst), .tx_if(bus_o), .CTS(cts_o),
        .Tx_Out(tx_out_o), .Tx_Busy(busy_o), .Tx_Done(done_o)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   acc_log[$];
    int   done_cnt = 0, overlap = 0, double_done = 0, abort_cnt = 0;
    logic prev_done = 1'b0;
    bit   mon_busy = 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected line, index i = i-th transmitted bit; parity from a popcount.
    function automatic logic [NUM_TX_BITS-1:0] ref_frame(input logic [7:0] d, input int odd);
        logic [NUM_TX_BITS-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int j = 0; j < DATA_BITS; j++) f[1+j] = d[DATA_BITS-1-j];
        f[1+DATA_BITS] = ((($countones(d) + odd) % 2) == 1);
        return f;
    endfunction

    // Accept tracker: a handshake at the coming edge is logged with that edge's cycle number.
    always @(negedge Clk) begin
        if (!Rst && bus.Tx_Ready && bus.Tx_Valid && cts) begin
            exp_q.push_back('{data: bus.Tx_Data_In, acc_cyc: cyc + 1});
            acc_log.push_back(cyc + 1);
        end
        if (tx_done) done_cnt++;
        if (tx_done && prev_done) double_done++;
        if (tx_busy && bus.Tx_Ready) overlap++;
        prev_done = tx_done;
    end

    // Line monitor
    exp_t                   item;
    logic [NUM_TX_BITS-1:0] frame, rx_bits;
    logic [7:0]             rx_word;
    logic                   prev_line = 1'b1;
    int                     line_errs, busy_errs;
    bit                     aborted;

    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst && prev_line && !tx_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_frame", 1, 0);
                end else begin
                    mon_busy  = 1'b1;
                    item      = exp_q.pop_front();
                    frame     = ref_frame(item.data, 0);
                    line_errs = 0;
                    busy_errs = 0;
                    aborted   = 1'b0;
                    check("start_time", cyc, item.acc_cyc);
                    for (int idx = 0; idx < FRAME_CLKS; idx++) begin
                        if (idx > 0) @(negedge Clk);
                        if (Rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx_out !== frame[idx/BIT_CLKS]) line_errs++;
                        if (tx_busy !== 1'b1 || bus.Tx_Ready !== 1'b0) busy_errs++;
                        if (idx % BIT_CLKS == BIT_CLKS / 2) rx_bits[idx/BIT_CLKS] = tx_out;
                    end
                    if (aborted) begin
                        abort_cnt++;
                    end else begin
                        for (int j = 0; j < DATA_BITS; j++) rx_word[DATA_BITS-1-j] = rx_bits[1+j];
                        check("line_bits", line_errs, 0);
                        check("busy_in_frame", busy_errs, 0);
                        check("rx_data", int'(rx_word), int'(item.data));
                        check("parity_bit", int'(rx_bits[1+DATA_BITS]), int'(frame[1+DATA_BITS]));
                        @(negedge Clk);
                        check("done_time", cyc, item.acc_cyc + FRAME_CLKS);
                        check("done_pulse", int'(tx_done), 1);
                        check("done_outputs", int'({tx_out, tx_busy, bus.Tx_Ready}), 3'b100);
                        @(negedge Clk);
                        check("done_single", int'(tx_done), 0);
                    end
                    mon_busy = 1'b0;
                end
            end
            prev_line = tx_out;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.Tx_Ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (bus.Tx_Ready !== 1'b1) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_accepts(input int target);
        int n = 0;
        while (acc_log.size() < target && n < 2000) begin
            tick();
            n++;
        end
        if (acc_log.size() < target) check("accept_timeout", acc_log.size(), target);
    endtask

    task automatic send_word(input logic [7:0] d);
        wait_ready("send");
        bus.Tx_Data_In = d;
        bus.Tx_Valid   = 1'b1;
        cts            = 1'b1;
        tick();
        bus.Tx_Valid   = 1'b0;
        bus.Tx_Data_In = 8'($urandom);
    endtask

    // Waits for the frame to finish; optionally scrambles inputs while busy.
    task automatic wait_idle(input bit garbage);
        int n = 0;
        while ((tx_busy || bus.Tx_Ready !== 1'b1) && n < FRAME_CLKS + 100) begin
            tick();
            n++;
            if (garbage && tx_busy) begin
                bus.Tx_Valid   = 1'($urandom);
                bus.Tx_Data_In = 8'($urandom);
                cts            = 1'($urandom);
            end else begin
                bus.Tx_Valid = 1'b0;
            end
        end
        if (tx_busy || bus.Tx_Ready !== 1'b1) check("idle_timeout", 0, 1);
    endtask

    task automatic reset_during(input logic [7:0] d, input int clk_into_frame);
        send_word(d);
        repeat (clk_into_frame) @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("midrst_tx_out", int'(tx_out), 1);
        check("midrst_busy", int'(tx_busy), 0);
        repeat (2) @(posedge Clk);
        #2 Rst = 1'b0;
        tick();
        check("midrst_ready_back", int'(bus.Tx_Ready), 1);
    endtask

    task automatic odd_frame_check(input logic [7:0] d);
        logic [NUM_TX_BITS-1:0] bits;
        int n = 0;
        while (bus_o.Tx_Ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        bus_o.Tx_Data_In = d;
        bus_o.Tx_Valid   = 1'b1;
        cts_o            = 1'b1;
        tick();
        bus_o.Tx_Valid   = 1'b0;
        for (int idx = 0; idx < FRAME_CLKS; idx++) begin
            @(negedge Clk);
            if (idx % BIT_CLKS == BIT_CLKS / 2) bits[idx/BIT_CLKS] = tx_out_o;
        end
        check("odd_frame", int'(bits), int'(ref_frame(d, 1)));
        @(negedge Clk);
        check("odd_done", int'(done_o), 1);
    endtask

    initial begin
        int         base, done_base, viol, n;
        logic [7:0] words[4] = '{8'hA5, 8'h01, 8'h00, 8'hFF};

        Rst = 1'b0; cts = 1'b0; cts_o = 1'b0;
        bus.Tx_Valid = 1'b0; bus.Tx_Data_In = '0;
        bus_o.Tx_Valid = 1'b0; bus_o.Tx_Data_In = '0;
        #1 Rst = 1'b1;
        #1;
        check("rst_tx_out", int'(tx_out), 1);
        check("rst_ready", int'(bus.Tx_Ready), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done), 0);
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b0;
        #1 check("ready_before_edge", int'(bus.Tx_Ready), 0);
        tick();
        check("ready_first_edge", int'(bus.Tx_Ready), 1);

        foreach (words[i]) begin
            send_word(words[i]);
            wait_idle(1'b0);
        end

        odd_frame_check(8'hA5);

        // CTS low holds the word off; CTS rising starts the frame on the next edge.
        base = acc_log.size();
        bus.Tx_Data_In = 8'h3C;
        bus.Tx_Valid   = 1'b1;
        cts            = 1'b0;
        viol = 0;
        repeat (50) begin
            @(negedge Clk);
            if (bus.Tx_Ready !== 1'b1 || tx_out !== 1'b1 || tx_busy !== 1'b0) viol++;
        end
        check("cts_hold", viol, 0);
        check("cts_no_accept", acc_log.size(), base);
        @(posedge Clk);
        #1 cts = 1'b1;
        tick();
        bus.Tx_Valid = 1'b0;
        check("cts_accept", acc_log.size(), base + 1);
        repeat (39) tick();
        cts = 1'b0;
        wait_idle(1'b0);
        cts = 1'b1;

        // Back-to-back with valid held high.
        base      = acc_log.size();
        done_base = done_cnt;
        wait_ready("b2b");
        bus.Tx_Data_In = 8'h3C;
        bus.Tx_Valid   = 1'b1;
        wait_accepts(base + 1);
        bus.Tx_Data_In = 8'hC3;
        wait_accepts(base + 2);
        bus.Tx_Valid = 1'b0;
        if (acc_log.size() >= base + 2)
            check("b2b_gap", acc_log[base+1] - acc_log[base], FRAME_CLKS + 2);
        wait_idle(1'b0);
        tick();
        check("b2b_done_pulses", done_cnt - done_base, 2);

        reset_during(8'hFF, 85);
        reset_during(8'h00, 5);
        send_word(8'h5A);
        wait_idle(1'b0);

        for (int i = 0; i < 14; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            bus.Tx_Data_In = d;
            bus.Tx_Valid   = 1'b1;
            cts            = 1'b0;
            repeat ($urandom_range(0, 4)) tick();
            send_word(d);
            wait_idle(1'b1);
        end

        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 1000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check("queue_empty", exp_q.size(), 0);
        check("aborted_frames", abort_cnt, 2);
        check("done_count", done_cnt, acc_log.size() - 2);
        check("ready_busy_overlap", overlap, 0);
        check("done_double", double_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
